// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point accumulator: Q-format width helpers,
// saturation constants and the frame FSM state type.
package fixed_point_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int MAX_Q_W = 64;

    function automatic int q_width(input int wi, input int wf);
        return wi + wf;
    endfunction

    // Patterns are right-aligned; callers slice the low w bits.
    function automatic logic [MAX_Q_W-1:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_Q_W-1:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_point_align.sv
// Combinational Q(WI_IN.WF_IN) -> Q(WI_OUT.WF_OUT) conversion: sign-extend,
// zero-pad or floor-truncate the fraction, saturate when integer bits are lost.
module fixed_point_align
    import fixed_point_pkg::*;
#(
    parameter int WI_IN  = 3,
    parameter int WF_IN  = 4,
    parameter int WI_OUT = 8,
    parameter int WF_OUT = 4
) (
    input  logic [WI_IN+WF_IN-1:0]   din_i,
    output logic [WI_OUT+WF_OUT-1:0] dout_o,
    output logic                     ovf_o
);

    localparam int W_IN  = q_width(WI_IN, WF_IN);
    localparam int W_MID = q_width(WI_IN, WF_OUT);
    localparam int W_OUT = q_width(WI_OUT, WF_OUT);
    localparam logic [MAX_Q_W-1:0] OUT_MAX = sat_max(W_OUT);
    localparam logic [MAX_Q_W-1:0] OUT_MIN = sat_min(W_OUT);

    // Input integer part with the output fraction length.
    logic [W_MID-1:0] mid;

    generate
        if (WF_OUT > WF_IN) begin : g_pad
            assign mid = {din_i, {(WF_OUT-WF_IN){1'b0}}};
        end else if (WF_OUT == WF_IN) begin : g_keep
            assign mid = din_i;
        end else begin : g_floor
            // Dropping low bits of a two's-complement value rounds toward -inf.
            logic [WF_IN-WF_OUT-1:0] dropped_unused;
            assign dropped_unused = din_i[WF_IN-WF_OUT-1:0];
            assign mid            = din_i[W_IN-1:WF_IN-WF_OUT];
        end

        if (WI_OUT > WI_IN) begin : g_ext
            assign dout_o = {{(WI_OUT-WI_IN){mid[W_MID-1]}}, mid};
            assign ovf_o  = 1'b0;
        end else if (WI_OUT == WI_IN) begin : g_same
            assign dout_o = mid;
            assign ovf_o  = 1'b0;
        end else begin : g_sat
            // Dropped integer bits plus the surviving sign bit must all agree.
            logic [WI_IN-WI_OUT:0] top_bits;
            assign top_bits = mid[W_MID-1:W_OUT-1];
            assign ovf_o    = !((&top_bits) || !(|top_bits));
            assign dout_o   = ovf_o ? (mid[W_MID-1] ? OUT_MIN[W_OUT-1:0] : OUT_MAX[W_OUT-1:0])
                                    : mid[W_OUT-1:0];
        end
    endgenerate

endmodule

// File: rtl/fixed_point_accumulator.sv
// Frame accumulator: aligns valid/ready samples into a saturating Q(WIA.WFA) sum
// and presents the converted frame result, count and overflow on an output handshake.
module fixed_point_accumulator
    import fixed_point_pkg::*;
#(
    parameter int WI    = 3,
    parameter int WF    = 4,
    parameter int WIA   = 8,
    parameter int WFA   = 4,
    parameter int WIO   = 8,
    parameter int WFO   = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI+WF-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_overFlow
);

    localparam int WA = q_width(WIA, WFA);
    localparam int WO = q_width(WIO, WFO);
    localparam logic [MAX_Q_W-1:0] ACC_MAX = sat_max(WA);
    localparam logic [MAX_Q_W-1:0] ACC_MIN = sat_min(WA);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    state_t             state_q;
    logic [WA-1:0]      acc_q;
    logic [WA-1:0]      acc_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WO-1:0]      out_data_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_ovf_q;

    logic [WA-1:0]      sample_aligned;
    logic               in_align_ovf_unused;
    logic [WA:0]        sum_wide;
    logic               add_ovf;
    logic [WO-1:0]      result_data;
    logic               result_sat;
    logic               accept;

    fixed_point_align #(
        .WI_IN  (WI),
        .WF_IN  (WF),
        .WI_OUT (WIA),
        .WF_OUT (WFA)
    ) u_align_in (
        .din_i  (in_data),
        .dout_o (sample_aligned),
        .ovf_o  (in_align_ovf_unused)
    );

    // One guard bit: a sign disagreement between the top two bits means the
    // equal-signed operands overflowed.
    always_comb begin
        sum_wide = {acc_q[WA-1], acc_q} + {sample_aligned[WA-1], sample_aligned};
        add_ovf  = sum_wide[WA] ^ sum_wide[WA-1];
        acc_d    = sum_wide[WA-1:0];
        if (add_ovf) begin
            acc_d = sum_wide[WA] ? ACC_MIN[WA-1:0] : ACC_MAX[WA-1:0];
        end
        count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        accept  = (state_q == ACCUM) && in_valid && in_ready_q;
    end

    fixed_point_align #(
        .WI_IN  (WIA),
        .WF_IN  (WFA),
        .WI_OUT (WIO),
        .WF_OUT (WFO)
    ) u_align_out (
        .din_i  (acc_d),
        .dout_o (result_data),
        .ovf_o  (result_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (clr) begin
            // Abort wins over both handshakes; last result registers are kept.
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        ovf_q   <= ovf_q | add_ovf;
                        if (in_last) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= result_data;
                            out_count_q <= count_d;
                            out_ovf_q   <= ovf_q | add_ovf | result_sat;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        acc_q       <= '0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_overFlow = out_ovf_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed scoreboard bench for fixed_point_accumulator (default formats plus a WFA=2 instance).
module tb_fixed_point_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [7:0]  out_count;
    logic        out_overFlow;

    logic        b_clr;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [6:0]  b_in_data;
    logic        b_in_last;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [11:0] b_out_data;
    logic [7:0]  b_out_count;
    logic        b_out_overFlow;

    typedef struct packed {
        logic [11:0] data;
        logic [7:0]  count;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fixed_point_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overFlow (out_overFlow)
    );

    fixed_point_accumulator #(.WFA(2)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (b_clr),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_data      (b_in_data),
        .in_last      (b_in_last),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_data     (b_out_data),
        .out_count    (b_out_count),
        .out_overFlow (b_out_overFlow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [11:0] d, input logic [7:0] c, input logic o);
        exp_t e;
        e.data  = d;
        e.count = c;
        e.ovf   = o;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [6:0] d, input logic last);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("[TB] sample 0x%02h last=%0d", d, last);
    endtask

    // Result must already be valid one cycle after the last acceptance.
    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"},  32'(out_data),     32'(e.data));
            chk({tag, "_count"}, 32'(out_count),    32'(e.count));
            chk({tag, "_ovf"},   32'(out_overFlow), 32'(e.ovf));
            $display("[TB] %s result data=0x%03h count=%0d ovf=%0d", tag, out_data, out_count, out_overFlow);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_hs_valid_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_hs_in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),     32'd1);
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_out_data",  32'(out_data),     32'd0);
        chk("rst_out_count", 32'(out_count),    32'd0);
        chk("rst_out_ovf",   32'(out_overFlow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 + 2.25 - 0.75 = 3.0
        push_exp(12'h030, 8'd3, 1'b0);
        send(7'h18, 1'b0);
        send(7'h24, 1'b0);
        send(7'h74, 1'b1);
        check_result("basic");
        handshake("basic");

        // 33 x 3.9375 overflows Q8.4 and pins at 127.9375
        push_exp(12'h7FF, 8'd33, 1'b1);
        for (int i = 0; i < 33; i++) send(7'h3F, (i == 32));
        check_result("sat");
        handshake("sat");
        push_exp(12'h010, 8'd1, 1'b0);
        send(7'h10, 1'b1);
        check_result("after_sat");
        handshake("after_sat");

        // WFA=2 instance: floor(0.0625)=0, floor(-0.0625)=-0.25
        chk("b_in_ready", 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1; b_in_data = 7'h01; b_in_last = 1'b0;
        @(posedge clk);
        #1;
        b_in_data = 7'h7F; b_in_last = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("floor_valid", 32'(b_out_valid),    32'd1);
        chk("floor_data",  32'(b_out_data),     32'h0FFC);
        chk("floor_count", 32'(b_out_count),    32'd2);
        chk("floor_ovf",   32'(b_out_overFlow), 32'd0);
        $display("[TB] floor result data=0x%03h count=%0d", b_out_data, b_out_count);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        chk("floor_hs_valid_low", 32'(b_out_valid), 32'd0);

        // Backpressure: 1.0 + 0.5 held for 5 cycles
        push_exp(12'h018, 8'd2, 1'b0);
        send(7'h10, 1'b0);
        send(7'h08, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data",  32'(out_data),  32'h018);
            chk("stall_out_count", 32'(out_count), 32'd2);
        end
        check_result("stall");
        handshake("stall");

        // clr mid-frame drops the partial sum and the sample offered with it
        send(7'h10, 1'b0);
        send(7'h10, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 7'h30; in_last = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        $display("[TB] clr in ACCUM");
        chk("clr_accum_in_ready",  32'(in_ready),  32'd1);
        chk("clr_accum_out_valid", 32'(out_valid), 32'd0);
        push_exp(12'h020, 8'd2, 1'b0);
        send(7'h10, 1'b0);
        send(7'h10, 1'b1);
        check_result("after_clr");
        handshake("after_clr");

        // clr in HOLD discards the pending result without a handshake
        push_exp(12'h010, 8'd1, 1'b0);
        send(7'h10, 1'b1);
        check_result("pre_clr_hold");
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        $display("[TB] clr in HOLD");
        chk("clr_hold_out_valid", 32'(out_valid), 32'd0);
        chk("clr_hold_in_ready",  32'(in_ready),  32'd1);
        chk("clr_hold_data_kept", 32'(out_data),  32'h010);
        push_exp(12'h008, 8'd1, 1'b0);
        send(7'h08, 1'b1);
        check_result("after_clr_hold");
        handshake("after_clr_hold");

        // Asynchronous reset mid-frame, off the clock edge
        send(7'h10, 1'b0);
        send(7'h10, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-frame");
        chk("arst_out_data",  32'(out_data),     32'd0);
        chk("arst_out_count", 32'(out_count),    32'd0);
        chk("arst_out_ovf",   32'(out_overFlow), 32'd0);
        chk("arst_out_valid", 32'(out_valid),    32'd0);
        chk("arst_in_ready",  32'(in_ready),     32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(12'h010, 8'd1, 1'b0);
        send(7'h10, 1'b1);
        check_result("after_arst");
        handshake("after_arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
